// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation amount finder.
//   rot_state_t : search controller states
//   ROT_LEFT / ROT_RIGHT : encoding of the lr direction input
package rot_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} rot_state_t;

    localparam logic ROT_LEFT  = 1'b1;
    localparam logic ROT_RIGHT = 1'b0;

endpackage

// File: rtl/rotator_comb.sv
// Combinational log-stage barrel rotator.
//   in  [W-1:0] : word to rotate
//   amt [N-1:0] : rotation amount
//   lr          : 1 = rotate left, 0 = rotate right
//   out [W-1:0] : rotated word
module rotator_comb
    import rot_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [2**N-1:0] in,
    input  logic [N-1:0]    amt,
    input  logic            lr,
    output logic [2**N-1:0] out
);
    localparam int W = 2**N;

    logic [W-1:0] stg [N+1];

    assign stg[0] = in;

    // Stage s rotates by 2**s when amt[s] is set.
    for (genvar s = 0; s < N; s++) begin : g_stage
        localparam int SH = 2**s;
        logic [W-1:0] rot_l;
        logic [W-1:0] rot_r;
        assign rot_l = {stg[s][W-1-SH:0], stg[s][W-1:W-SH]};
        assign rot_r = {stg[s][SH-1:0], stg[s][W-1:SH]};
        assign stg[s+1] = amt[s] ? ((lr == ROT_LEFT) ? rot_l : rot_r) : stg[s];
    end

    assign out = stg[N];

endmodule

// File: rtl/rotate_amount_finder.sv
// Recovers the rotation amount relating an original word to a rotated one,
// trying one amount per cycle in ascending order.
//   clk, reset        : clock, synchronous active-high reset
//   start             : request a search (accepted only while ready)
//   in, rot [W-1:0]   : original and rotated words, captured on accept
//   lr                : direction to decode, 1 = left, 0 = right
//   ready             : high in IDLE
//   done              : one-cycle pulse when found/amt become valid
//   found             : a matching amount exists
//   amt [N-1:0]       : smallest matching amount, 0 if none
//
// state  | meaning
// IDLE   | waiting for start, ready high
// SEARCH | testing amount k against rot_q, one per cycle
// DONE   | result valid, done pulse high for this cycle
module rotate_amount_finder
    import rot_pkg::*;
#(
    parameter int N = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2**N-1:0] in,
    input  logic [2**N-1:0] rot,
    input  logic            lr,
    output logic            ready,
    output logic            done,
    output logic            found,
    output logic [N-1:0]    amt
);
    localparam int W = 2**N;

    rot_state_t   state;
    logic [W-1:0] in_q;
    logic [W-1:0] rot_q;
    logic         lr_q;
    logic [N:0]   k;
    logic [W-1:0] trial;
    logic         match;

    rotator_comb #(.N(N)) u_rotator (
        .in  (in_q),
        .amt (k[N-1:0]),
        .lr  (lr_q),
        .out (trial)
    );

    assign match = (trial == rot_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            found <= 1'b0;
            amt   <= '0;
            k     <= '0;
            in_q  <= '0;
            rot_q <= '0;
            lr_q  <= ROT_RIGHT;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        in_q  <= in;
                        rot_q <= rot;
                        lr_q  <= lr;
                        k     <= '0;
                        found <= 1'b0;
                        amt   <= '0;
                        ready <= 1'b0;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (match) begin
                        found <= 1'b1;
                        amt   <= k[N-1:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (k == (N+1)'(W-1)) begin
                        // Last amount tried without a match; stop before k wraps.
                        found <= 1'b0;
                        amt   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + (N+1)'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_amount_finder.sv
module tb_rotate_amount_finder;
    localparam int N = 5;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in_w = '0;
    logic [31:0] rot_w = '0;
    logic        lr_w = 1'b0;
    logic        ready, done, found;
    logic [4:0]  amt;

    int total = 0;
    int bad = 0;

    rotate_amount_finder #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in_w),
        .rot   (rot_w),
        .lr    (lr_w),
        .ready (ready),
        .done  (done),
        .found (found),
        .amt   (amt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(logic [31:0] x, int s);
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] rotr(logic [31:0] x, int s);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: computes the answer by brute force at accept time and
    // derives when each output must change from the accept edge index.
    int   m_edge = 0;
    int   m_acc = 0;
    int   m_keff = 0;
    bit   m_busy = 0;
    bit   m_valid = 0;
    bit   m_ready = 1, m_done = 0, m_found = 0;
    bit   r_found = 0;
    logic [4:0] m_amt = '0, r_amt = '0;

    always @(posedge clk) begin
        m_edge++;
        if (reset) begin
            m_busy = 0; m_ready = 1; m_done = 0; m_found = 0; m_amt = '0;
            m_valid = 1;
        end else if (!m_busy) begin
            m_done  = 0;
            m_ready = 1;
            if (start) begin
                r_found = 0;
                r_amt   = '0;
                for (int s = 0; s < W; s++) begin
                    if (!r_found && ((lr_w ? rotl(in_w, s) : rotr(in_w, s)) == rot_w)) begin
                        r_found = 1;
                        r_amt   = 5'(s);
                    end
                end
                m_keff  = r_found ? int'(r_amt) : W - 1;
                m_acc   = m_edge;
                m_busy  = 1;
                m_ready = 0;
                m_found = 0;
                m_amt   = '0;
            end
        end else begin
            if (m_edge == m_acc + m_keff + 1) begin
                m_done  = 1;
                m_found = r_found;
                m_amt   = r_amt;
            end else if (m_edge == m_acc + m_keff + 2) begin
                m_done  = 0;
                m_ready = 1;
                m_busy  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ready", 32'(ready), 32'(m_ready));
            chk("model_done",  32'(done),  32'(m_done));
            chk("model_found", 32'(found), 32'(m_found));
            chk("model_amt",   32'(amt),   32'(m_amt));
        end
    end

    // Directed search with literal expectations; cycle n counts edges from
    // the accepting edge (n = 1).
    task automatic run_case(string name, logic [31:0] a, logic [31:0] r, logic l,
                            logic ef, logic [4:0] ea, int ecyc, bit poke);
        int  n;
        bit  got;
        @(negedge clk);
        in_w = a; rot_w = r; lr_w = l; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        in_w = ~a; rot_w = ~r; lr_w = ~l;
        got = 0;
        while (n < 40) begin
            if (done) begin
                got = 1;
                break;
            end
            if (poke && n == 2) begin
                in_w = 32'hFFFF_FFFF; rot_w = 32'hFFFF_FFFF; lr_w = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_done_cycle"}, n, ecyc);
        chk({name, "_found"}, 32'(found), 32'(ef));
        chk({name, "_amt"}, 32'(amt), 32'(ea));
        @(posedge clk);
        @(negedge clk);
        chk({name, "_ready_back"}, 32'(ready), 32'd1);
        chk({name, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n, d1, d2, dcount;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_amt",   32'(amt),   32'd0);

        run_case("left4",  32'h0000_00AB, 32'h0000_0AB0, 1'b1, 1'b1, 5'd4, 6, 0);
        run_case("right4", 32'h0000_00AB, 32'hB000_000A, 1'b0, 1'b1, 5'd4, 6, 0);
        run_case("nomatch", 32'h0000_00AB, 32'h0000_00AC, 1'b1, 1'b0, 5'd0, 33, 0);
        run_case("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd0, 2, 0);
        run_case("alt", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, 5'd1, 3, 0);
        run_case("busy", 32'h0000_00AB, 32'h0000_0AB0, 1'b1, 1'b1, 5'd4, 6, 1);

        for (int s = 0; s < W; s++) begin
            run_case("sweep_l", 32'h0000_00AB, rotl(32'h0000_00AB, s), 1'b1, 1'b1, 5'(s), s + 2, 0);
            run_case("sweep_r", 32'h0000_00AB, rotr(32'h0000_00AB, s), 1'b0, 1'b1, 5'(s), s + 2, 0);
        end

        // Reset mid-search: abort the no-match search and expect no done pulse.
        @(negedge clk);
        in_w = 32'h0000_00AB; rot_w = 32'h0000_00AC; lr_w = 1'b1; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (n < 9) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_found", 32'(found), 32'd0);
        chk("abort_amt",   32'(amt),   32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", dcount, 0);

        // Back-to-back: start held high, two searches one IDLE cycle apart.
        @(negedge clk);
        in_w = 32'h0000_00AB; rot_w = 32'h0000_0AB0; lr_w = 1'b1; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        d1 = 0; d2 = 0;
        while (n < 60 && d2 == 0) begin
            if (done) begin
                if (d1 == 0) d1 = n;
                else d2 = n;
            end
            if (d2 == 0) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("b2b_first_done", d1, 6);
        chk("b2b_second_done", d2, 13);
        chk("b2b_amt", 32'(amt), 32'd4);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
